uart_tx_fifo: RTL and testbench

- Parametrised serial transmitter, the successor to the fixed 9600-baud 8N1 character-pattern sender.
- Accepts words over a valid/ready handshake into a small FIFO and serialises them on `tx` as start, data LSB-first, optional parity, then 1 or 2 stop bits.
- Adds a break-generation mode and status outputs.
- Sits between the console/teleprinter logic and the FPGA serial pin.

---
 rtl/uart_tx_fifo_if.sv | 8 +
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready word handshake into the transmitter FIFO.
interface uart_tx_fifo_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   modport master (output tx_data, tx_valid, input tx_ready);
   modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable framing and line break.
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 4
) (
   input  logic                   clk100,
   input  logic                   reset_n,
   uart_tx_fifo_if.slave          bus,
   input  logic                   send_break,
   output logic                   tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int DIV   = (CLOCK_FREQ + BAUD / 2) / BAUD;
   localparam int DW    = $clog2(DIV);
   localparam int AW    = $clog2(DEPTH);
   localparam int FRAME = 1 + DATA_BITS + (PARITY != 0 ? 1 : 0) + STOP_BITS;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);
   localparam logic [3:0] B_LAST = 4'(FRAME - 1);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, BREAK = 3'd5;

   logic [1:0]           rst_q, rst_d;
   logic                 arst_n;
   logic [2:0]           state_q, state_d;
   logic [DW-1:0]        div_q, div_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DATA_BITS-1:0] sh_q, sh_d, head;
   logic                 par_q, par_d, tx_q, tx_d, busy_q, busy_d;
   logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]          count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic                 wr, pop, tick, go, empty;

   assign rst_d         = {rst_q[0], 1'b1};
   assign arst_n        = rst_q[1];
   assign bus.tx_ready  = count_q != (AW + 1)'(DEPTH);
   assign wr            = bus.tx_valid && bus.tx_ready;
   assign empty         = count_q == '0;
   assign tick          = div_q == '0;
   assign head          = mem_q[rp_q];
   assign tx            = tx_q;
   assign busy          = busy_q;
   assign fifo_count    = count_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      par_d   = par_q;
      go      = 1'b0;
      div_d   = (tick || state_q == IDLE) ? DIV_LAST : div_q - 1'b1;
      unique case (state_q)
         IDLE:  go = 1'b1;
         START: if (tick) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA:  if (tick) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = sh_q >> 1;
            if (cnt_q == D_LAST) begin
               state_d = PARITY != 0 ? PAR : STOP;
               cnt_d   = '0;
            end
         end
         PAR:   if (tick) state_d = STOP;
         STOP:  if (tick) begin
            cnt_d = cnt_q + 1'b1;
            go    = cnt_q == S_LAST;
         end
         BREAK: if (tick) begin
            // Line stays low for at least one frame, then one stop bit via STOP
            if (cnt_q != B_LAST) cnt_d = cnt_q + 1'b1;
            else if (!send_break) begin
               state_d = STOP;
               cnt_d   = S_LAST;
            end
         end
         default: state_d = IDLE;
      endcase
      pop = go && !send_break && !empty;
      if (go) begin
         state_d = send_break ? BREAK : (empty ? IDLE : START);
         cnt_d   = '0;
      end
      if (pop) begin
         sh_d  = head;
         par_d = (^head) ^ (PARITY == 1);
      end
      wp_d    = wp_q + AW'(wr);
      rp_d    = rp_q + AW'(pop);
      count_d = count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
      tx_d    = (state_d == START || state_d == BREAK) ? 1'b0 :
                state_d == DATA ? sh_d[0] : state_d == PAR ? par_d : 1'b1;
      busy_d  = state_d != IDLE || count_d != '0;
   end

   always_ff @(posedge clk100 or negedge reset_n)
      if (!reset_n) rst_q <= 2'b00;
      else rst_q <= rst_d;

   always_ff @(posedge clk100 or negedge arst_n)
      if (!arst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end

   always_ff @(posedge clk100)
      if (wr) mem_q[wp_q] <= bus.tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO flow, break and reset.
module tb_uart_tx_fifo;
   logic       clk100 = 1'b0;
   logic       reset_n = 1'b0;
   logic       brk0 = 1'b0, brk1 = 1'b0, brk2 = 1'b0;
   logic       tx0, tx1, tx2, busy0, busy1, busy2;
   logic [2:0] fc0, fc1, fc2;
   int         errs = 0, checks = 0, max_fc = 0;

   uart_tx_fifo_if #(.DATA_BITS(8)) b0 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) b1 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) b2 ();

   uart_tx_fifo #(.CLOCK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u0 (
      .clk100(clk100), .reset_n(reset_n), .bus(b0), .send_break(brk0), .tx(tx0), .busy(busy0), .fifo_count(fc0));
   uart_tx_fifo #(.CLOCK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) u1 (
      .clk100(clk100), .reset_n(reset_n), .bus(b1), .send_break(brk1), .tx(tx1), .busy(busy1), .fifo_count(fc1));
   uart_tx_fifo #(.CLOCK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) u2 (
      .clk100(clk100), .reset_n(reset_n), .bus(b2), .send_break(brk2), .tx(tx2), .busy(busy2), .fifo_count(fc2));

   always #5 clk100 = ~clk100;

   always @(negedge clk100)
      if (32'(fc0) > max_fc) max_fc = 32'(fc0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic txw(input int w);
      return w == 0 ? tx0 : (w == 1 ? tx1 : tx2);
   endfunction

   function automatic logic rdy(input int w);
      return w == 0 ? b0.tx_ready : (w == 1 ? b1.tx_ready : b2.tx_ready);
   endfunction

   task automatic put(input int w, input logic [7:0] d);
      int n = 0;
      @(negedge clk100);
      if (w == 0) begin b0.tx_data = d; b0.tx_valid = 1'b1; end
      else if (w == 1) begin b1.tx_data = d[6:0]; b1.tx_valid = 1'b1; end
      else begin b2.tx_data = d[6:0]; b2.tx_valid = 1'b1; end
      while (rdy(w) !== 1'b1 && n < 3000) begin @(negedge clk100); n++; end
      if (n >= 3000) chk("put_timeout", 0, 1);
      @(posedge clk100);
      #1;
      b0.tx_valid = 1'b0;
      b1.tx_valid = 1'b0;
      b2.tx_valid = 1'b0;
   endtask

   task automatic wait_start(input int w);
      int n = 0;
      while (txw(w) !== 1'b0 && n < 3000) begin @(negedge clk100); n++; end
      if (n >= 3000) chk("start_timeout", 0, 1);
   endtask

   // Samples n consecutive bits at mid-bit, starting from the first low cycle of a start bit
   task automatic sample(input int w, input int div, input int n, output logic [63:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         repeat (i == 0 ? div / 2 : div) @(negedge clk100);
         v[i] = txw(w);
      end
   endtask

   logic [7:0]  words [9] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h18, 8'h5A, 8'hA5, 8'h42};
   logic [7:0]  pat = 8'h55;
   logic [63:0] v;
   int          lo, hb, drop_at;

   initial begin
      b0.tx_valid = 1'b0; b0.tx_data = '0;
      b1.tx_valid = 1'b0; b1.tx_data = '0;
      b2.tx_valid = 1'b0; b2.tx_data = '0;
      repeat (3) @(negedge clk100);
      chk("rst_tx", 32'(tx0), 1);
      chk("rst_ready", 32'(b0.tx_ready), 1);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_count", 32'(fc0), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk100);

      put(0, pat);
      for (int k = 0; k <= 161; k++) begin
         @(negedge clk100);
         if (k == 0 || k == 161 || (k - 1) % 16 == 0 || k % 16 == 0)
            chk($sformatf("f55_tx_k%0d", k), 32'(tx0),
                k == 0 || k > 144 ? 1 : (k <= 16 ? 0 : 32'(pat[(k - 17) / 16])));
         if (k == 1 || k == 160 || k == 161) chk($sformatf("f55_busy_k%0d", k), 32'(busy0), k <= 160 ? 1 : 0);
      end

      put(1, 8'h41);
      wait_start(1);
      sample(1, 4, 11, v);
      chk("even_frame", 32'(v[10:0]), 1666);
      chk("even_busy_in", 32'(busy1), 1);
      repeat (2) @(negedge clk100);
      chk("even_busy_end", 32'(busy1), 0);
      put(2, 8'h41);
      wait_start(2);
      sample(2, 4, 11, v);
      chk("odd_frame", 32'(v[10:0]), 1922);

      drop_at = -1;
      fork
         begin
            int idx = 0, n = 0;
            while (idx < 6 && n < 5000) begin
               @(negedge clk100);
               n++;
               b0.tx_data = 8'(idx + 1);
               b0.tx_valid = 1'b1;
               if (b0.tx_ready === 1'b1) idx++;
               else if (drop_at < 0) drop_at = idx;
            end
            @(posedge clk100);
            #1 b0.tx_valid = 1'b0;
         end
         begin
            wait_start(0);
            sample(0, 16, 60, v);
         end
      join
      chk("ready_drop_after", drop_at, 5);
      chk("max_count", max_fc, 4);
      for (int f = 0; f < 6; f++)
         chk($sformatf("b2b_frame%0d", f), 32'(v[10 * f +: 10]), 32'({1'b1, 8'(f + 1), 1'b0}));
      repeat (20) @(negedge clk100);
      chk("b2b_idle", 32'(busy0), 0);

      @(negedge clk100);
      brk0 = 1'b1;
      lo = 0;
      hb = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk100);
         if (i == 2) brk0 = 1'b0;
         if (tx0 === 1'b0) lo++;
         if (tx0 === 1'b1 && busy0 === 1'b1) hb++;
      end
      chk("brk_low_clks", lo, 160);
      chk("brk_stop_clks", hb, 16);
      chk("brk_busy_end", 32'(busy0), 0);

      put(0, 8'h0A);
      wait_start(0);
      fork
         begin
            repeat (80) @(negedge clk100);
            brk0 = 1'b1;
            repeat (112) @(negedge clk100);
            brk0 = 1'b0;
         end
         sample(0, 16, 21, v);
      join
      chk("brk_frame_0a", 32'(v[9:0]), 532);
      chk("brk_after_frame", 32'(v[20:10]), 1024);
      repeat (8) @(negedge clk100);
      chk("brk2_busy_end", 32'(busy0), 0);

      put(0, 8'h7E);
      wait_start(0);
      put(0, 8'h01);
      put(0, 8'h02);
      @(negedge clk100);
      chk("rst_pre_count", 32'(fc0), 2);
      chk("rst_pre_busy", 32'(busy0), 1);
      repeat (66) @(negedge clk100);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_tx", 32'(tx0), 1);
      chk("rstmid_count", 32'(fc0), 0);
      chk("rstmid_ready", 32'(b0.tx_ready), 1);
      chk("rstmid_busy", 32'(busy0), 0);
      repeat (3) @(negedge clk100);
      reset_n = 1'b1;
      lo = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk100);
         if (tx0 === 1'b0) lo++;
      end
      chk("rstmid_no_residual", lo, 0);
      chk("rstmid_idle_busy", 32'(busy0), 0);

      fork
         for (int i = 0; i < 9; i++) begin
            put(0, words[i]);
            if (i % 3 == 2) repeat (200) @(negedge clk100);
         end
         for (int i = 0; i < 9; i++) begin
            wait_start(0);
            sample(0, 16, 10, v);
            chk($sformatf("wrap_word%0d", i), 32'(v[9:0]), 32'({1'b1, words[i], 1'b0}));
         end
      join
      repeat (20) @(negedge clk100);
      chk("wrap_empty", 32'(fc0), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
